// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types and helpers for the pe_cube result path.
//                Holds the bank state encoding, the lane byte type and the
//                lane-count derivation used by pe_cube and its neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    // Occupancy of one snapshot bank
    typedef logic bank_state_t;
    localparam bank_state_t BANK_EMPTY = 1'b0;
    localparam bank_state_t BANK_FULL  = 1'b1;

    // One PE result
    typedef logic [7:0] lane_byte_t;

    // Total PE lanes in a cube; must agree with pe_cube
    function automatic int pe_lanes(input int array_num, input int block_num,
                                    input int cube_num);
        return array_num * block_num * cube_num;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_lane_pick.sv
`default_nettype none
// ============================================================================
//  Module      : pe_lane_pick
//  Description : Lowest-set-bit priority encoder over a lane mask. Reports
//                the index of the lowest set bit, whether any bit is set and
//                whether exactly one bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_lane_pick #(
    parameter int LANES = 27,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic [LANES-1:0] i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found,
    output logic             o_single
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when one bit was set
    always_comb begin
        o_found  = |i_mask;
        o_single = o_found && ((i_mask & (i_mask - LANES'(1))) == '0);
    end

endmodule
`default_nettype wire

// File: rtl/pe_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : pe_result_drain
//  Description : Captures pe_cube result snapshots into two ping-pong banks
//                (FIFO order) and serialises the valid lanes of each bank as
//                a byte-per-beat valid/ready stream tagged with the lane
//                index and a last flag. A sticky flag records dropped
//                snapshots.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_result_drain
    import pe_pkg::*;
#(
    parameter  int ARRAY_NUM = 3,
    parameter  int BLOCK_NUM = 3,
    parameter  int CUBE_NUM  = 3,
    localparam int LANES     = pe_lanes(ARRAY_NUM, BLOCK_NUM, CUBE_NUM),
    localparam int IDX_W     = $clog2(LANES)
) (
    input  logic               iClk,
    input  logic               iRstN,
    input  logic [8*LANES-1:0] iResult,
    input  logic [LANES-1:0]   iResultValid,
    input  logic               iReady,
    input  logic               iClearOvf,
    output logic               oValid,
    output logic [7:0]         oData,
    output logic [IDX_W-1:0]   oLaneIdx,
    output logic               oLast,
    output logic               oOverflow,
    output logic               oBusy
);

    // Bank storage, indexed by bank number
    bank_state_t        r_state [2];
    logic [8*LANES-1:0] r_data  [2];
    logic [LANES-1:0]   r_pend  [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic               r_overflow;

    logic [IDX_W-1:0]   w_idx;
    logic               w_found;
    logic               w_single;
    logic               w_valid;
    logic               w_xfer;
    logic               w_release;
    logic               w_snap;
    logic               w_wr_free;
    logic               w_capture;
    logic [LANES-1:0]   w_pend_act;
    logic [8*LANES-1:0] w_data_act;
    lane_byte_t         w_byte;

    assign w_pend_act = r_pend[r_rd_ptr];
    assign w_data_act = r_data[r_rd_ptr];

    pe_lane_pick #(
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_lane_pick (
        .i_mask   (w_pend_act),
        .o_idx    (w_idx),
        .o_found  (w_found),
        .o_single (w_single)
    );

    // Handshake and capture decisions; the write bank counts as free when
    // its final beat leaves on this same edge
    always_comb begin
        w_valid   = (r_state[r_rd_ptr] == BANK_FULL);
        w_xfer    = w_valid && iReady;
        w_release = w_xfer && w_single;
        w_snap    = |iResultValid;
        w_wr_free = (r_state[r_wr_ptr] == BANK_EMPTY) ||
                    (w_release && (r_rd_ptr == r_wr_ptr));
        w_capture = w_snap && w_wr_free;
        w_byte    = w_data_act[{w_idx, 3'b000} +: 8];
    end

    // Output decode from registered bank state, forced to zero when idle
    always_comb begin
        oValid   = w_valid;
        oData    = '0;
        oLaneIdx = '0;
        oLast    = 1'b0;
        if (w_valid) begin
            oData    = w_byte;
            oLaneIdx = w_idx;
            oLast    = w_single;
        end
        oOverflow = r_overflow;
        oBusy     = (r_state[0] == BANK_FULL) || (r_state[1] == BANK_FULL);
    end

    // Bank update: a capture reloads a bank, a transfer retires one lane
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= BANK_EMPTY;
                r_data[b]  <= '0;
                r_pend[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_capture && (r_wr_ptr == 1'(b))) begin
                    r_state[b] <= BANK_FULL;
                    r_data[b]  <= iResult;
                    r_pend[b]  <= iResultValid;
                end else if (w_xfer && (r_rd_ptr == 1'(b))) begin
                    r_pend[b] <= r_pend[b] & ~(LANES'(1) << w_idx);
                    if (w_single) begin
                        r_state[b] <= BANK_EMPTY;
                    end
                end
            end
        end
    end

    // FIFO pointers advance on capture and on bank release
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_release) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Sticky drop flag; a drop on the clearing edge keeps it set
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_overflow <= 1'b0;
        end else if (w_snap && !w_wr_free) begin
            r_overflow <= 1'b1;
        end else if (iClearOvf) begin
            r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire
